// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO get-side reader.
//   N_BITS_DEF : default data word width (matches the FIFO data width)
//   RD_LAT_DEF : default read latency from req_get to data_get valid
//   rd_state_e : reader FSM state encoding
package fifo_pkg;

  localparam int N_BITS_DEF = 32;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_get_reader_if.sv
// Downstream stream interface of the get-side reader.
//   out_data  : data word presented by the reader
//   out_valid : out_data holds a word
//   out_ready : consumer accepts the word
// Handshake: a word transfers on every clock edge where out_valid and
// out_ready are both high; once out_valid rises, out_valid and out_data
// hold steady until that transfer happens.
// master = reader side, slave = consumer side.
interface fifo_get_reader_if import fifo_pkg::*; #(
  parameter int N_BITS = N_BITS_DEF
) ();

  logic [N_BITS-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/get_skid_buffer.sv
// Small synchronous FIFO that absorbs words returning from the get FIFO.
// Entry 0 is always the head, so head_data comes straight from a flop.
//   clk, reset          : clock, synchronous active-high reset
//   clear               : drop all entries (dominates push/pop)
//   push, push_data     : write a word at the tail
//   pop                 : remove the head word
//   occ                 : number of stored entries
//   head_data/head_valid: registered head of the buffer
module get_skid_buffer import fifo_pkg::*; #(
  parameter  int N_BITS = N_BITS_DEF,
  parameter  int DEPTH  = 2,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [N_BITS-1:0] push_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic [N_BITS-1:0] head_data,
  output logic              head_valid
);

  logic [N_BITS-1:0] data_q [DEPTH];
  logic [N_BITS-1:0] data_d [DEPTH];
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              head_valid_q, head_valid_d;
  logic              pop_eff;
  logic [OCC_W-1:0]  wr_idx;

  always_comb begin
    data_d  = data_q;
    occ_d   = occ_q;
    pop_eff = pop && (occ_q != '0);
    wr_idx  = occ_q - OCC_W'(pop_eff);
    if (clear) begin
      occ_d = '0;
    end else begin
      if (pop_eff) begin
        for (int i = 0; i < DEPTH - 1; i++) data_d[i] = data_q[i + 1];
      end
      // The write slot is computed after the pop so a full buffer can
      // accept a word in the same cycle it releases one.
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (OCC_W'(i) == wr_idx) data_d[i] = push_data;
        end
      end
      occ_d = wr_idx + OCC_W'(push && (wr_idx < OCC_W'(DEPTH)));
    end
    head_valid_d = (occ_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      occ_q        <= '0;
      head_valid_q <= 1'b0;
    end else begin
      data_q       <= data_d;
      occ_q        <= occ_d;
      head_valid_q <= head_valid_d;
    end
  end

  assign occ        = occ_q;
  assign head_data  = data_q[0];
  assign head_valid = head_valid_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !clear && !pop_eff && (occ_q == OCC_W'(DEPTH))));

endmodule

// File: rtl/fifo_get_reader.sv
// Get-side consumer of the mixed-clock FIFO, clocked by the FIFO get clock.
// Requests words while credit allows, captures them RD_LAT cycles later
// into a skid buffer, and presents them downstream on a valid/ready stream.
// A flush drains and discards everything in the FIFO and in flight.
//   clk_get, reset : clock, synchronous active-high reset
//   enable         : permits fetching from the FIFO
//   flush          : one-cycle drain-and-discard request
//   empty_in       : FIFO empty flag
//   data_get_in    : FIFO read data
//   req_get_out    : get request to the FIFO
//   dn             : downstream stream (out_data/out_valid/out_ready)
//   flush_done     : one-cycle pulse when a flush completes
//   busy           : flushing, or any word in flight or buffered
//   words_read     : words accepted downstream, wrapping
//   state_dbg      : current FSM state
module fifo_get_reader import fifo_pkg::*; #(
  parameter int N_BITS     = N_BITS_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                clk_get,
  input  logic                reset,
  input  logic                enable,
  input  logic                flush,
  input  logic                empty_in,
  input  logic [N_BITS-1:0]   data_get_in,
  output logic                req_get_out,
  fifo_get_reader_if.master   dn,
  output logic                flush_done,
  output logic                busy,
  output logic [CNT_W-1:0]    words_read,
  output rd_state_e           state_dbg
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  if ((RD_LAT < 1) || (RD_LAT > 3) || (SKID_DEPTH < RD_LAT + 1)) begin : g_cfg_check
    $error("fifo_get_reader: RD_LAT must be 1..3 and SKID_DEPTH >= RD_LAT+1");
  end

  rd_state_e         state_q, state_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic              flush_done_q, flush_done_d;
  logic [CNT_W-1:0]  words_read_q, words_read_d;

  logic [OCC_W-1:0]  occ;
  logic [N_BITS-1:0] head_data;
  logic              head_valid;
  logic              pop, push, clear, flush_enter;
  int                inflight;

  assign pop         = head_valid && dn.out_ready;
  assign flush_enter = flush && (state_q != FLUSH);
  // Words landing while flushing (or in the entry cycle) are discarded.
  assign clear       = flush_enter;
  assign push        = pipe_q[RD_LAT-1] && (state_q != FLUSH);

  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + (pipe_q[i] ? 1 : 0);
  end

  // Credit counts buffered plus in-flight words, minus the word leaving
  // this cycle, so the skid buffer can never be overrun.
  always_comb begin
    req_get_out = 1'b0;
    case (state_q)
      RUN:     req_get_out = !empty_in &&
                             ((int'(occ) + inflight - int'(pop)) < SKID_DEPTH);
      FLUSH:   req_get_out = !empty_in;
      default: req_get_out = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      FLUSH: begin
        if (empty_in && (inflight == 0)) begin
          state_d      = enable ? RUN : IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_enter) state_d = FLUSH;

    // Latency pipe: bit i set means a request issued i+1 cycles ago.
    pipe_d    = '0;
    pipe_d[0] = req_get_out;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i - 1];

    words_read_d = words_read_q + CNT_W'(pop);
  end

  always_ff @(posedge clk_get) begin
    if (reset) begin
      state_q      <= IDLE;
      pipe_q       <= '0;
      flush_done_q <= 1'b0;
      words_read_q <= '0;
    end else begin
      state_q      <= state_d;
      pipe_q       <= pipe_d;
      flush_done_q <= flush_done_d;
      words_read_q <= words_read_d;
    end
  end

  get_skid_buffer #(
    .N_BITS (N_BITS),
    .DEPTH  (SKID_DEPTH)
  ) u_skid (
    .clk        (clk_get),
    .reset      (reset),
    .clear      (clear),
    .push       (push),
    .push_data  (data_get_in),
    .pop        (pop),
    .occ        (occ),
    .head_data  (head_data),
    .head_valid (head_valid)
  );

  assign dn.out_valid = head_valid;
  assign dn.out_data  = head_data;
  assign flush_done   = flush_done_q;
  assign words_read   = words_read_q;
  assign state_dbg    = state_q;
  assign busy         = (state_q == FLUSH) || (pipe_q != '0) || (occ != '0);

endmodule

// File: doc/fifo_get_reader.md
Name: fifo_get_reader

Overview:
- Get-side consumer for the mixed-clock FIFO. Runs on the FIFO's get clock.
- Issues req_get into the FIFO and watches its empty flag. Captures data_get after a fixed read latency.
- Re-presents captured words downstream on a valid/ready interface through a small skid buffer, so that stalls never lose data.
- Also provides a flush operation that drains and discards the FIFO contents, plus a delivered-word counter.

Parameters:
- N_BITS, 32, data word width; matches the FIFO data width.
- RD_LAT, 1, clk_get cycles from req_get_out high (with empty_in low) to data_get_in valid; legal range 1..3.
- SKID_DEPTH, 2, skid buffer entries; must be >= RD_LAT+1.
- CNT_W, 16, width of the words_read counter.

Ports:
- clk_get, in, 1, single clock; same as the FIFO get clock.
- reset, in, 1, synchronous, active-high.
- enable, in, 1, permits fetching from the FIFO.
- flush, in, 1, single-cycle pulse requesting a FIFO drain-and-discard.
- empty_in, in, 1, FIFO empty flag (clk_get domain).
- data_get_in, in, N_BITS, FIFO read data.
- req_get_out, out, 1, get request to the FIFO.
- out_data, out, N_BITS, downstream data.
- out_valid, out, 1, downstream data valid.
- out_ready, in, 1, downstream accept.
- flush_done, out, 1, one-cycle pulse when a flush completes.
- busy, out, 1, high in FLUSH, or while any word is in flight or buffered.
- words_read, out, CNT_W, count of words accepted downstream.

Behaviour:
- One clock: clk_get. Reset is synchronous and active-high, named reset.
- Reset values: state=IDLE; req_get_out=0, out_valid=0, out_data=0, flush_done=0, busy=0, words_read=0; in-flight pipe cleared; skid buffer empty.
- Reset asserted mid-operation:
  - Buffered and in-flight words are dropped.
  - Words already removed from the FIFO are lost; this is accepted and is not an error.
- States:
  - IDLE: no requests issued. Buffered words still drain downstream.
  - IDLE->RUN when enable=1.
  - RUN->IDLE when enable=0. In-flight words still land in the skid buffer.
  - Any state->FLUSH on flush=1. flush has priority over enable.
  - FLUSH->(enable ? RUN : IDLE) when empty_in=1 and in-flight count=0. flush_done pulses high for that one cycle.
- Credit rule in RUN:
  - req_get_out = ~empty_in & (occ + inflight - pop < SKID_DEPTH).
  - occ = skid entries; inflight = requests issued but not yet returned (0..RD_LAT); pop = out_valid & out_ready.
  - req_get_out is combinational from registered state/counters, empty_in and out_ready.
- Capture: a request issued at cycle t writes data_get_in into the skid buffer at the edge ending cycle t+RD_LAT. Track this with an RD_LAT-deep valid shift register.
- Throughput: with out_ready=1 and the FIFO non-empty, one word per cycle sustained.
- Downstream interface:
  - out_valid/out_data come from the skid head, registered.
  - Once out_valid=1, out_data must hold stable until out_ready=1.
  - Ordering is strict FIFO.
- Simultaneous capture and pop on a full skid buffer: legal. occ is unchanged.
- FLUSH behaviour:
  - The skid buffer is cleared on entry and out_valid is forced to 0.
  - req_get_out = ~empty_in every cycle, with no credit check.
  - Returning words are discarded and not counted.
  - flush while already in FLUSH is ignored.
- words_read increments on out_valid & out_ready and wraps modulo 2^CNT_W.
- The skid buffer must never overflow. Overflow is an assertion in simulation.
- busy = (state==FLUSH) | (inflight!=0) | (occ!=0).

Decomposition:
- Shared package (fifo_pkg):
  - N_BITS default.
  - Reader state encoding: IDLE=2'd0, RUN=2'd1, FLUSH=2'd2.
  - RD_LAT default.
- One sub-module: get_skid_buffer, a SKID_DEPTH-entry synchronous FIFO with push, pop, clear, occ, and head data/valid outputs.
- The top level holds the FSM, credit logic, latency pipe and counter.

Test Plan:
- Reset then enable=1, FIFO holding 5 words 0xA0..0xA4, out_ready=1 -> req_get_out high 5 consecutive cycles; out_valid high 5 cycles starting RD_LAT+1 cycles after the first req; data 0xA0..0xA4 in order; words_read=5; busy returns to 0.
- FIFO holding 8 words, out_ready=0 -> exactly SKID_DEPTH requests issued; out_valid=1 with out_data=first word held stable. Then out_ready=1 -> remaining words follow at one per cycle with no gaps or loss.
- Alternate out_ready 1/0 each cycle over 16 words -> 16 words delivered in order, no skid overflow assertion, words_read=16.
- 6 words in FIFO, 2 buffered, flush pulse -> out_valid drops next cycle; req_get_out high until empty_in=1; single flush_done pulse after the last in-flight return; words_read unchanged.
- words_read preloaded near wrap (run 2^CNT_W+3 words; CNT_W overridden to 4) -> counter reads 3.
- reset asserted with 2 words in flight and 1 buffered -> next cycle all outputs at reset values; late data_get_in returns ignored.
